// File: rtl/fwd_pkg.sv
// Shared constants for the operand-forwarding / hazard unit: operand source
// codes, register index geometry and the source-code width helper.
package fwd_pkg;

    localparam int REG_AW        = 6;
    localparam int X0_IDX        = 0;

    localparam int SEL_RF        = 0;
    localparam int SEL_WB        = 1;
    localparam int SEL_ZERO      = 2;
    localparam int SEL_FWD0      = 3;

    localparam int N_FWD_DEFAULT = 2;
    localparam int SEL_W         = $clog2(N_FWD_DEFAULT + 3);

    // Source-code width for an arbitrary number of forwarding buses.
    function automatic int sel_width(input int n_fwd);
        return $clog2(n_fwd + 3);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Issue-stage bundle between the issue logic (master) and the forwarding /
// hazard unit (slave): issue request, operand sources and registered operands.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int N_FWD   = 2,
    parameter int STALL_W = 32
);
    localparam int SEL_WIDTH = sel_width(N_FWD);

    logic                      iss_valid;
    logic                      iss_ready;
    logic [REG_AW-1:0]         iss_rs1;
    logic [REG_AW-1:0]         iss_rs2;
    logic [REG_AW-1:0]         iss_rs3;
    logic [2:0]                iss_use;
    logic                      iss_wen;
    logic [REG_AW-1:0]         iss_rd;
    logic                      flush;
    logic [XLEN-1:0]           rf_rd1;
    logic [XLEN-1:0]           rf_rd2;
    logic [XLEN-1:0]           rf_rd3;
    logic [N_FWD-1:0]          fwd_valid;
    logic [REG_AW*N_FWD-1:0]   fwd_rd;
    logic [XLEN*N_FWD-1:0]     fwd_data;
    logic                      wb_valid;
    logic [REG_AW-1:0]         wb_rd;
    logic [XLEN-1:0]           wb_data;
    logic                      op_valid;
    logic [XLEN-1:0]           op_a;
    logic [XLEN-1:0]           op_b;
    logic [XLEN-1:0]           op_c;
    logic [3*SEL_WIDTH-1:0]    op_sel;
    logic [STALL_W-1:0]        stall_cycles;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rs3, iss_use, iss_wen, iss_rd,
               flush, rf_rd1, rf_rd2, rf_rd3, fwd_valid, fwd_rd, fwd_data,
               wb_valid, wb_rd, wb_data,
        input  iss_ready, op_valid, op_a, op_b, op_c, op_sel, stall_cycles
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rs3, iss_use, iss_wen, iss_rd,
               flush, rf_rd1, rf_rd2, rf_rd3, fwd_valid, fwd_rd, fwd_data,
               wb_valid, wb_rd, wb_data,
        output iss_ready, op_valid, op_a, op_b, op_c, op_sel, stall_cycles
    );

endinterface

// File: rtl/fwd_operand_sel.sv
// Combinational source selection for one operand: x0, forwarding buses
// (lowest index wins), writeback bypass, register file, or hazard.
module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int N_FWD  = 2,
    parameter int PCNT_W = 2
) (
    input  logic [REG_AW-1:0]          rs_i,
    input  logic                       use_i,
    input  logic [PCNT_W-1:0]          pend_i,
    input  logic [N_FWD-1:0]           fwd_valid_i,
    input  logic [REG_AW*N_FWD-1:0]    fwd_rd_i,
    input  logic [XLEN*N_FWD-1:0]      fwd_data_i,
    input  logic                       wb_valid_i,
    input  logic [REG_AW-1:0]          wb_rd_i,
    input  logic [XLEN-1:0]            wb_data_i,
    input  logic [XLEN-1:0]            rf_data_i,
    output logic [XLEN-1:0]            value_o,
    output logic [sel_width(N_FWD)-1:0] sel_o,
    output logic                       hazard_o
);
    localparam int SEL_WIDTH = sel_width(N_FWD);

    logic hit;

    always_comb begin
        value_o  = '0;
        sel_o    = SEL_WIDTH'(SEL_ZERO);
        hazard_o = 1'b0;
        hit      = 1'b0;
        if (rs_i != REG_AW'(X0_IDX)) begin
            value_o = rf_data_i;
            sel_o   = SEL_WIDTH'(SEL_RF);
            if (use_i) begin
                // Two or more outstanding writes: a bus hit may be the older one.
                if (int'(pend_i) >= 2) begin
                    hazard_o = 1'b1;
                end else begin
                    for (int unsigned j = 0; j < N_FWD; j++) begin
                        if (!hit && fwd_valid_i[j] &&
                            fwd_rd_i[j*REG_AW +: REG_AW] == rs_i) begin
                            value_o = fwd_data_i[j*XLEN +: XLEN];
                            sel_o   = SEL_WIDTH'(SEL_FWD0 + j);
                            hit     = 1'b1;
                        end
                    end
                    if (!hit) begin
                        if (wb_valid_i && wb_rd_i == rs_i) begin
                            value_o = wb_data_i;
                            sel_o   = SEL_WIDTH'(SEL_WB);
                        end else if (pend_i != '0) begin
                            hazard_o = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// RV32IF issue-stage forwarding and hazard unit: pending-write scoreboard,
// issue stall generation, stall counter and registered operands toward EX.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int N_FWD   = 2,
    parameter int NREGS   = 64,
    parameter int PCNT_W  = 2,
    parameter int STALL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_unit_if.slave   bus
);
    localparam int SEL_WIDTH = sel_width(N_FWD);

    logic [PCNT_W-1:0]    pend_q [NREGS];
    logic [PCNT_W-1:0]    pend_d [NREGS];
    logic [REG_AW-1:0]    rs     [3];
    logic [XLEN-1:0]      rf     [3];
    logic [XLEN-1:0]      val    [3];
    logic [SEL_WIDTH-1:0] sel    [3];
    logic [2:0]           haz;
    logic [XLEN-1:0]      op_q   [3];
    logic [SEL_WIDTH-1:0] sel_q  [3];
    logic                 op_valid_q;
    logic [STALL_W-1:0]   stall_q;
    logic                 waw_full, stall, accept, inc_en, dec_en;

    assign rs[0] = bus.iss_rs1;
    assign rs[1] = bus.iss_rs2;
    assign rs[2] = bus.iss_rs3;
    assign rf[0] = bus.rf_rd1;
    assign rf[1] = bus.rf_rd2;
    assign rf[2] = bus.rf_rd3;

    for (genvar k = 0; k < 3; k++) begin : g_sel
        fwd_operand_sel #(
            .XLEN   (XLEN),
            .N_FWD  (N_FWD),
            .PCNT_W (PCNT_W)
        ) u_sel (
            .rs_i        (rs[k]),
            .use_i       (bus.iss_use[k]),
            .pend_i      (pend_q[rs[k]]),
            .fwd_valid_i (bus.fwd_valid),
            .fwd_rd_i    (bus.fwd_rd),
            .fwd_data_i  (bus.fwd_data),
            .wb_valid_i  (bus.wb_valid),
            .wb_rd_i     (bus.wb_rd),
            .wb_data_i   (bus.wb_data),
            .rf_data_i   (rf[k]),
            .value_o     (val[k]),
            .sel_o       (sel[k]),
            .hazard_o    (haz[k])
        );
    end

    assign waw_full = bus.iss_wen && bus.iss_rd != REG_AW'(X0_IDX) &&
                      pend_q[bus.iss_rd] == '1;
    assign stall         = bus.iss_valid && (|haz || waw_full);
    assign bus.iss_ready = !stall && !bus.flush;
    assign accept        = bus.iss_valid && bus.iss_ready;
    assign inc_en        = accept && bus.iss_wen && bus.iss_rd != REG_AW'(X0_IDX);
    assign dec_en        = bus.wb_valid && bus.wb_rd != REG_AW'(X0_IDX);

    // Issue and retire on the same register cancel out.
    always_comb begin
        pend_d = pend_q;
        if (inc_en && !(dec_en && bus.wb_rd == bus.iss_rd))
            pend_d[bus.iss_rd] = pend_q[bus.iss_rd] + 1'b1;
        if (dec_en && !(inc_en && bus.wb_rd == bus.iss_rd) && pend_q[bus.wb_rd] != '0)
            pend_d[bus.wb_rd] = pend_q[bus.wb_rd] - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) pend_q[r] <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                op_q[k]  <= '0;
                sel_q[k] <= SEL_WIDTH'(SEL_ZERO);
            end
            op_valid_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            pend_q     <= pend_d;
            op_valid_q <= accept;
            if (accept) begin
                op_q  <= val;
                sel_q <= sel;
            end
            if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.op_valid     = op_valid_q;
    assign bus.op_a         = op_q[0];
    assign bus.op_b         = op_q[1];
    assign bus.op_c         = op_q[2];
    assign bus.op_sel       = {sel_q[2], sel_q[1], sel_q[0]};
    assign bus.stall_cycles = stall_q;

    a_wb_underflow: assert property (@(posedge clk) disable iff (rst)
        !(dec_en && pend_q[bus.wb_rd] == '0));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a cycle-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int SW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, wen, fl, wbv;
    logic [2:0]  use_m;
    logic [5:0]  rd, wbr;
    logic [5:0]  rs_in [3];
    logic [31:0] rf_in [3];
    logic [1:0]  fv;
    logic [5:0]  frd   [2];
    logic [31:0] fd    [2];
    logic [31:0] wbd;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.XLEN(32), .N_FWD(2), .STALL_W(32)) bus ();

    fwd_hazard_unit #(
        .XLEN    (32),
        .N_FWD   (2),
        .NREGS   (64),
        .PCNT_W  (2),
        .STALL_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.iss_valid = iv;
    assign bus.iss_rs1   = rs_in[0];
    assign bus.iss_rs2   = rs_in[1];
    assign bus.iss_rs3   = rs_in[2];
    assign bus.iss_use   = use_m;
    assign bus.iss_wen   = wen;
    assign bus.iss_rd    = rd;
    assign bus.flush     = fl;
    assign bus.rf_rd1    = rf_in[0];
    assign bus.rf_rd2    = rf_in[1];
    assign bus.rf_rd3    = rf_in[2];
    assign bus.fwd_valid = fv;
    assign bus.fwd_rd    = {frd[1], frd[0]};
    assign bus.fwd_data  = {fd[1], fd[0]};
    assign bus.wb_valid  = wbv;
    assign bus.wb_rd     = wbr;
    assign bus.wb_data   = wbd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int sel_of(input int k);
        return int'(bus.op_sel[k*SW +: SW]);
    endfunction

    // ---------------- reference model ----------------
    int          mp [64];
    bit          mvalid = 0;
    bit          exp_ov;
    logic [31:0] exp_val [3];
    int          exp_sel [3];
    logic [31:0] exp_stall;

    function automatic void msel(input int k, output logic [31:0] v, output int s, output bit h);
        int r;
        r = int'(rs_in[k]);
        h = 0; s = SEL_RF; v = rf_in[k];
        if (r == 0) begin v = 0; s = SEL_ZERO; return; end
        if (!use_m[k]) return;
        if (mp[r] >= 2) begin h = 1; return; end
        for (int j = 0; j < 2; j++)
            if (fv[j] && int'(frd[j]) == r) begin v = fd[j]; s = SEL_FWD0 + j; return; end
        if (wbv && int'(wbr) == r) begin v = wbd; s = SEL_WB; return; end
        if (mp[r] != 0) h = 1;
    endfunction

    always @(negedge clk) begin
        logic [31:0] nv [3];
        int          ns [3];
        bit          h, anyh, full, stl, rdy, acc;
        int          inc_r, dec_r;
        if (mvalid) begin
            chk("op_valid", {63'd0, bus.op_valid}, {63'd0, exp_ov});
            chk("op_a", {32'd0, bus.op_a}, {32'd0, exp_val[0]});
            chk("op_b", {32'd0, bus.op_b}, {32'd0, exp_val[1]});
            chk("op_c", {32'd0, bus.op_c}, {32'd0, exp_val[2]});
            for (int k = 0; k < 3; k++) chk("op_sel", 64'(sel_of(k)), 64'(exp_sel[k]));
            chk("stall_cycles", {32'd0, bus.stall_cycles}, {32'd0, exp_stall});
        end
        if (rst) begin
            for (int r = 0; r < 64; r++) mp[r] = 0;
            for (int k = 0; k < 3; k++) begin exp_val[k] = 0; exp_sel[k] = SEL_ZERO; end
            exp_ov = 0; exp_stall = 0; mvalid = 1;
        end else if (mvalid) begin
            anyh = 0;
            for (int k = 0; k < 3; k++) begin msel(k, nv[k], ns[k], h); anyh |= h; end
            full = wen && rd != 0 && mp[rd] == 3;
            stl  = iv && (anyh || full);
            rdy  = !stl && !fl;
            chk("iss_ready", {63'd0, bus.iss_ready}, {63'd0, rdy});
            if (stl && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            acc = iv && rdy;
            exp_ov = acc;
            if (acc) for (int k = 0; k < 3; k++) begin exp_val[k] = nv[k]; exp_sel[k] = ns[k]; end
            inc_r = (acc && wen && rd != 0) ? int'(rd) : -1;
            dec_r = (wbv && wbr != 0) ? int'(wbr) : -1;
            if (inc_r != dec_r) begin
                if (inc_r >= 0) mp[inc_r]++;
                if (dec_r >= 0 && mp[dec_r] > 0) mp[dec_r]--;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        iv = 0; wen = 0; rd = 0; fl = 0; use_m = 0; fv = 0;
        wbv = 0; wbr = 0; wbd = 0;
        for (int k = 0; k < 3; k++) begin rs_in[k] = 0; rf_in[k] = 0; end
        for (int j = 0; j < 2; j++) begin frd[j] = 0; fd[j] = 0; end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(); rst = 1;
        cyc(); cyc();
        chk("rst_op_valid", {63'd0, bus.op_valid}, 64'd0);
        chk("rst_stall", {32'd0, bus.stall_cycles}, 64'd0);
        rst = 0;

        // plain register-file reads
        iv = 1; rs_in[0] = 5; rs_in[1] = 6; use_m = 3'b011;
        rf_in[0] = 32'h11; rf_in[1] = 32'h22;
        #1 chk("t1_ready", {63'd0, bus.iss_ready}, 64'd1);
        cyc();
        chk("t1_valid", {63'd0, bus.op_valid}, 64'd1);
        chk("t1_op_a", {32'd0, bus.op_a}, 64'h11);
        chk("t1_op_b", {32'd0, bus.op_b}, 64'h22);
        chk("t1_sel_a", 64'(sel_of(0)), 64'd0);
        chk("t1_sel_b", 64'(sel_of(1)), 64'd0);
        idle(); cyc();
        chk("t1_drop", {63'd0, bus.op_valid}, 64'd0);
        chk("t1_hold", {32'd0, bus.op_a}, 64'h11);

        // bus 0 wins over bus 1
        iv = 1; wen = 1; rd = 5; cyc(); idle();
        iv = 1; rs_in[0] = 5; use_m = 3'b001; fv = 2'b11;
        frd[0] = 5; fd[0] = 32'hBB; frd[1] = 5; fd[1] = 32'hAA;
        cyc();
        chk("t2_op_a", {32'd0, bus.op_a}, 64'hBB);
        chk("t2_sel_a", 64'(sel_of(0)), 64'd3);
        idle(); wbv = 1; wbr = 5; cyc(); idle();

        // load-use resolved by same-cycle writeback
        iv = 1; wen = 1; rd = 33; cyc(); idle();
        iv = 1; rs_in[2] = 33; use_m = 3'b100; rf_in[2] = 32'hDEAD;
        #1 chk("t3_stall", {63'd0, bus.iss_ready}, 64'd0);
        cyc(); cyc(); cyc();
        chk("t3_cnt", {32'd0, bus.stall_cycles}, 64'd3);
        wbv = 1; wbr = 33; wbd = 32'h3F80_0000;
        #1 chk("t3_bypass_ready", {63'd0, bus.iss_ready}, 64'd1);
        cyc();
        chk("t3_op_c", {32'd0, bus.op_c}, 64'h3F80_0000);
        chk("t3_sel_c", 64'(sel_of(2)), 64'd1);
        chk("t3_cnt_hold", {32'd0, bus.stall_cycles}, 64'd3);
        idle();

        // WAW: two pending writes block forwarding until one retires
        iv = 1; wen = 1; rd = 7; cyc(); cyc(); idle();
        iv = 1; rs_in[0] = 7; use_m = 3'b001; fv = 2'b01; frd[0] = 7; fd[0] = 32'h77;
        #1 chk("t4_stall", {63'd0, bus.iss_ready}, 64'd0);
        cyc(); cyc();
        wbv = 1; wbr = 7;
        #1 chk("t4_stall_wb", {63'd0, bus.iss_ready}, 64'd0);
        cyc();
        wbv = 0;
        #1 chk("t4_ready", {63'd0, bus.iss_ready}, 64'd1);
        cyc();
        chk("t4_op_a", {32'd0, bus.op_a}, 64'h77);
        chk("t4_sel_a", 64'(sel_of(0)), 64'd3);
        chk("t4_cnt", {32'd0, bus.stall_cycles}, 64'd6);
        idle(); wbv = 1; wbr = 7; cyc(); idle();

        // x0 ignores forwarding and writes
        iv = 1; rs_in[0] = 0; use_m = 3'b001; fv = 2'b01; frd[0] = 0; fd[0] = 32'hFF;
        wen = 1; rd = 0;
        cyc();
        chk("t5_op_a", {32'd0, bus.op_a}, 64'd0);
        chk("t5_sel_a", 64'(sel_of(0)), 64'd2);
        idle();

        // flush blocks accept and leaves the scoreboard alone
        iv = 1; rs_in[0] = 5; use_m = 3'b001; rf_in[0] = 32'h55; wen = 1; rd = 9; fl = 1;
        #1 chk("t6_ready", {63'd0, bus.iss_ready}, 64'd0);
        cyc();
        chk("t6_valid", {63'd0, bus.op_valid}, 64'd0);
        chk("t6_hold", {32'd0, bus.op_a}, 64'd0);
        idle();
        iv = 1; rs_in[0] = 9; use_m = 3'b001; rf_in[0] = 32'h99;
        #1 chk("t6_no_pend", {63'd0, bus.iss_ready}, 64'd1);
        cyc();
        chk("t6_op_a", {32'd0, bus.op_a}, 64'h99);
        chk("t6_cnt", {32'd0, bus.stall_cycles}, 64'd6);
        idle();

        // pending counter full stalls a further write
        iv = 1; wen = 1; rd = 20; cyc(); cyc(); cyc();
        #1 chk("t7_full", {63'd0, bus.iss_ready}, 64'd0);
        cyc();
        chk("t7_cnt", {32'd0, bus.stall_cycles}, 64'd7);
        idle();

        // reset while stalled
        iv = 1; wen = 1; rd = 12; cyc(); idle();
        iv = 1; rs_in[1] = 12; use_m = 3'b010; rf_in[1] = 32'hC;
        cyc();
        rst = 1; cyc();
        chk("t8_valid", {63'd0, bus.op_valid}, 64'd0);
        chk("t8_op_a", {32'd0, bus.op_a}, 64'd0);
        chk("t8_op_b", {32'd0, bus.op_b}, 64'd0);
        chk("t8_sel", {55'd0, bus.op_sel}, 64'b010_010_010);
        chk("t8_cnt", {32'd0, bus.stall_cycles}, 64'd0);
        rst = 0;
        #1 chk("t8_ready", {63'd0, bus.iss_ready}, 64'd1);
        cyc();
        chk("t8_op_b", {32'd0, bus.op_b}, 64'hC);
        idle(); cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and hazard unit for the RV32IF issue stage. Three source operands (rs1/rs2/rs3, with rs3 for fused FP ops) each pick the newest value from N_FWD result buses, the writeback bus, or the register file. A per-register pending-write scoreboard stalls issue on unresolved RAW and on WAW overflow. Selected operands are registered toward EX.

## Interface
- XLEN, 32: operand/data width
- N_FWD, 2: forwarding buses, index 0 = youngest/highest priority
- NREGS, 64: architectural registers; idx[5]=1 → FP file; idx 0 = x0
- PCNT_W, 2: pending-write counter width per register
- STALL_W, 32: stall performance counter width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  instruction presented for issue
- iss_ready  out  1  issue accepted this cycle (combinational)
- iss_rs1/rs2/rs3  in  6 each  source indices
- iss_use  in  3  operand-used mask {rs3,rs2,rs1}
- iss_wen  in  1  instruction writes iss_rd
- iss_rd  in  6  destination index
- flush  in  1  kill current issue and op_valid
- rf_rd1/rd2/rd3  in  XLEN each  register-file read data for rs1..rs3
- fwd_valid  in  N_FWD  forwarding bus valid
- fwd_rd  in  6*N_FWD  forwarding bus destination
- fwd_data  in  XLEN*N_FWD  forwarding bus data
- wb_valid  in  1  writeback commit
- wb_rd  in  6  writeback destination
- wb_data  in  XLEN  writeback data
- op_valid  out  1  registered operands valid
- op_a/op_b/op_c  out  XLEN each  registered operands
- op_sel  out  3*SEL_W  registered source code per operand (debug/verification)
- stall_cycles  out  STALL_W  saturating stall counter

## Operation
- Writes: index 0 is never written. Writes to it are ignored for pending and forwarding, and it always reads 0.
- Scoreboard: pending[r] counts outstanding writes.
  - Accepted issue with iss_wen and iss_rd≠0 increments pending[iss_rd].
  - wb_valid with wb_rd≠0 decrements pending[wb_rd].
  - Both on the same register in the same cycle: unchanged.
  - Decrement at 0 holds at 0 and is illegal (assertion).
- Per-operand selection (sub-module), first match wins:
  - rs==0 → 0, SEL_ZERO
  - pending[rs]≥2 → hazard
  - lowest j with fwd_valid[j] && fwd_rd[j]==rs → fwd_data[j], SEL_FWD0+j
  - wb_valid && wb_rd==rs → wb_data, SEL_WB
  - pending[rs]==0 → rf data, SEL_RF
  - otherwise → hazard
- Operands not set in iss_use never raise a hazard. Their selected value is don't-care but deterministic: rf data, or 0 for rs==0.
- Stall/accept:
  - stall = iss_valid && (any used-operand hazard || (iss_wen && iss_rd≠0 && pending[iss_rd]==2^PCNT_W−1)).
  - iss_ready = !stall && !flush.
  - Accept = iss_valid && iss_ready.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- Reset values: pending all 0, op_valid 0, op_a/b/c 0, op_sel all SEL_ZERO, stall_cycles 0.
- Latency: operands are captured on the accept edge. op_valid=1 for exactly one cycle per accept, with no backpressure.
- Non-accept cycles: op_valid←0 and op_a/b/c/op_sel hold their values.
- flush: blocks accept and forces op_valid←0 next cycle. Pending counts are not cleared, because in-flight writes still retire through wb.
- Same-cycle events:
  - An issue reading rs while wb retires the last pending write of rs is not stalled (wb bypass).
  - Issue's own increment of rd does not affect its own operand reads that cycle.
- rst mid-operation clears all state on the next edge regardless of other inputs.

## Structure
- Package fwd_pkg holds:
  - SEL_W = $clog2(N_FWD+3)
  - SEL_RF=0, SEL_WB=1, SEL_ZERO=2, SEL_FWD0=3 (SEL_FWD0+j for bus j)
  - REG_AW=6, X0_IDX=0
- Sub-module fwd_operand_sel is combinational and instantiated three times. It takes rs, pending[rs], the bus vectors, wb and rf data, and outputs value, sel and hazard.
- The top level holds the scoreboard, the stall counter and the output registers.

## Test plan
- Reset, then issue rs1=5, rs2=6 with pending 0 and rf_rd1=0x11, rf_rd2=0x22 → next cycle op_valid=1, op_a=0x11, op_b=0x22, sel=SEL_RF.
- Issue writes rd=5 (pending 1). Next instruction reads rs1=5 with fwd bus 1 carrying rd=5, 0xAA and bus 0 rd=5, 0xBB → op_a=0xBB, sel=SEL_FWD0.
- Load-use: pending[33]=1, no bus match, rs3=33 in use → iss_ready=0 and stall_cycles counts up. wb_valid rd=33, 0x3F800000 → accepted that cycle, op_c=0x3F800000, sel=SEL_WB.
- WAW: two writes to rd=7 outstanding (pending 2) → reads of 7 stall even with a bus match. One wb → pending 1 and a bus match then forwards.
- x0: rs1=0 while fwd bus has rd=0, 0xFF → op_a=0, SEL_ZERO. iss_wen with rd=0 leaves pending unchanged.
- flush in an accept-eligible cycle → op_valid=0 next cycle, pending unchanged. rst mid-stall → all outputs return to reset values next cycle.
